uart_frame_sender: RTL and testbench
====================================

// Module: uart_frame_sender
// PURPOSE
//  Periodic/triggered framed-packet generator feeding a byte-wide UART TX (valid/ready) in the clk_a domain.
//  Frame = HDR0, HDR1, LEN, LEN payload bytes [, checksum]. Generalises the fixed 5-byte beacon
//  (55 5A 02 D3 84) to runtime payload/length, configurable period and manual triggering.
//  Sits between sensor/coordinate logic and the UART transmitter.
// PARAMETERS
//  PERIOD_CYCLES  5_000_000  auto-mode frame start interval in clk_a cycles (>=2)
//  MAX_PAYLOAD    8          max payload bytes (1..32)
//  HDR0           8'h55      first header byte
//  HDR1           8'h5A      second header byte
// PORTS
//  clk_a       in   1               system clock
//  rst_n       in   1               async active-low reset
//  i_payload   in   8*MAX_PAYLOAD   payload; byte k = i_payload[8k+7:8k], byte 0 sent first
//  i_len       in   8               payload length request
//  i_auto_en   in   1               1 = periodic frames every PERIOD_CYCLES
//  i_trigger   in   1               1-cycle pulse requests one frame
//  o_tx_data   out  8               byte to UART TX
//  o_tx_valid  out  1               byte valid
//  i_tx_ready  in   1               UART accepts byte when valid&ready at posedge
//  o_busy      out  1               frame in progress
//  o_frame_done out 1               1-cycle pulse on acceptance of last byte
// BEHAVIOUR
//  - Reset is rst_n, asynchronous, active-low; clock is clk_a. All outputs 0; FSM IDLE; counters 0; pending 0.
//  - FSM: IDLE -> LOAD -> SEND -> IDLE.
//    IDLE: if start request (pending|trigger|period wrap) -> LOAD.
//    LOAD (1 cycle): snapshot i_payload, len = min(i_len, MAX_PAYLOAD); byte index = 0; clear pending.
//    SEND: o_tx_valid=1, o_tx_data = current byte; advance index only on valid&ready.
//      Last byte accepted -> o_frame_done pulse, valid drops next cycle, -> IDLE.
//  - Latency: trigger in IDLE at cycle n -> o_tx_valid=1 with HDR0 at cycle n+2.
//  - o_tx_data/o_tx_valid held stable while valid & !ready; no valid deassert before acceptance.
//  - Back-to-back: transfers may occur every cycle when ready stays high.
//  - Snapshot guarantees i_payload/i_len changes mid-frame do not affect the current frame.
//  - Period counter: when i_auto_en=1 counts 0..PERIOD_CYCLES-1 and wraps, wrap = start request;
//    when i_auto_en=0 held at 0. Counter runs independent of FSM (fixed cadence).
//  - Request while busy (trigger or wrap): sets 1-deep pending; extra requests coalesce.
//    Pending frame starts from IDLE the cycle after the current frame ends.
//  - len 0: frame = HDR0 HDR1 00 [chk]. i_len > MAX_PAYLOAD: LEN byte sent = MAX_PAYLOAD.
//  - o_busy = 1 in LOAD and SEND.
//  - Reset mid-frame: outputs drop asynchronously; frame abandoned, no frame_done; pending cleared.
// CONFIGURATION
//  FRAME_CHECKSUM_EN defined: after last payload byte append checksum = (LEN + sum payload bytes) mod 256;
//    frame length = LEN+4; frame_done on checksum acceptance.
//  Not defined: no checksum byte; frame length = LEN+3; frame_done on last payload (or LEN) byte.
// TESTING
//  1 no CHK, i_len=2, byte0=D3, byte1=84, trigger, ready=1 -> 55 5A 02 D3 84 on 5 consecutive cycles, done once.
//  2 CHK, same stimulus -> 55 5A 02 D3 84 59; done on the 59 byte.
//  3 ready low 10 cycles while sending 5A -> data stays 5A, valid stays 1, no byte skipped/duplicated.
//  4 PERIOD_CYCLES=1000, auto=1, ready=1 -> HDR0 valid rises every 1000 cycles; trigger mid-frame -> one extra frame right after.
//  5 i_len=0 -> 55 5A 00 [00]; i_len=12, MAX_PAYLOAD=8 -> LEN byte 08, 8 payload bytes.
//  6 rst_n low during payload byte 1 -> valid/busy 0 immediately; after release, idle until next request, next frame starts at HDR0.

Source files
------------

// File: rtl/uart_frame_sender.sv
// uart_frame_sender: builds HDR0, HDR1, LEN, payload[, checksum] frames for a
// valid/ready byte-wide UART TX. Frames start on a trigger pulse or on every
// wrap of a free-running period counter when auto mode is enabled.
// Optional feature macro: FRAME_CHECKSUM_EN appends (LEN + sum payload) mod 256.
module uart_frame_sender #(
  parameter int unsigned PERIOD_CYCLES = 5_000_000,
  parameter int unsigned MAX_PAYLOAD   = 8,
  parameter logic [7:0]  HDR0          = 8'h55,
  parameter logic [7:0]  HDR1          = 8'h5A
) (
  input  logic                     clk_a,
  input  logic                     rst_n,
  input  logic [8*MAX_PAYLOAD-1:0] i_payload,
  input  logic [7:0]               i_len,
  input  logic                     i_auto_en,
  input  logic                     i_trigger,
  output logic [7:0]               o_tx_data,
  output logic                     o_tx_valid,
  input  logic                     i_tx_ready,
  output logic                     o_busy,
  output logic                     o_frame_done
);

  localparam int unsigned CW      = $clog2(PERIOD_CYCLES);
  localparam int unsigned IW      = $clog2(MAX_PAYLOAD + 4);
  localparam logic [7:0]  MAX_LEN = 8'(MAX_PAYLOAD);
`ifdef FRAME_CHECKSUM_EN
  localparam logic [IW-1:0] TAIL = IW'(3);
`else
  localparam logic [IW-1:0] TAIL = IW'(2);
`endif

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic          pending;
  logic [7:0]    snap [MAX_PAYLOAD];
  logic [7:0]    len;
  logic [IW-1:0] idx;
  logic [IW-1:0] last_idx;
  logic [7:0]    pbyte;
  logic          wrap;
  logic          req_now;
  logic          busy;

  assign wrap     = i_auto_en && (cnt == CW'(PERIOD_CYCLES - 1));
  assign req_now  = i_trigger | wrap;
  assign busy     = (state != S_IDLE);
  assign o_busy   = busy;
  assign last_idx = IW'(len) + TAIL;

  // Fixed-cadence period counter, independent of frame activity.
  always_ff @(posedge clk_a or negedge rst_n) begin
    if (!rst_n)                  cnt <= '0;
    else if (!i_auto_en || wrap) cnt <= '0;
    else                         cnt <= cnt + CW'(1);
  end

  // One-deep pending request; a request during LOAD survives the LOAD clear.
  always_ff @(posedge clk_a or negedge rst_n) begin
    if (!rst_n)                pending <= 1'b0;
    else if (busy && req_now)  pending <= 1'b1;
    else if (state == S_LOAD)  pending <= 1'b0;
  end

  // FSM state register.
  always_ff @(posedge clk_a or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Frame snapshot in LOAD and byte index advance on each accepted byte.
  always_ff @(posedge clk_a or negedge rst_n) begin
    if (!rst_n) begin
      len <= '0;
      idx <= '0;
      for (int unsigned k = 0; k < MAX_PAYLOAD; k++) snap[k] <= '0;
    end else if (state == S_LOAD) begin
      len <= (i_len > MAX_LEN) ? MAX_LEN : i_len;
      idx <= '0;
      for (int unsigned k = 0; k < MAX_PAYLOAD; k++) snap[k] <= i_payload[8*k +: 8];
    end else if (state == S_SEND && i_tx_ready) begin
      idx <= idx + IW'(1);
    end
  end

  // Payload byte selected by the current index (index 3 is payload byte 0).
  always_comb begin
    pbyte = '0;
    for (int unsigned k = 0; k < MAX_PAYLOAD; k++)
      if (idx == IW'(k + 3)) pbyte = snap[k];
  end

`ifdef FRAME_CHECKSUM_EN
  logic [7:0] chk;

  // Checksum over the snapshot: LEN plus the first LEN payload bytes.
  always_comb begin
    chk = len;
    for (int unsigned k = 0; k < MAX_PAYLOAD; k++)
      if (8'(k) < len) chk = chk + snap[k];
  end
`endif

  // Next-state and output decode.
  always_comb begin
    state_nxt    = state;
    o_tx_valid   = 1'b0;
    o_tx_data    = '0;
    o_frame_done = 1'b0;
    case (state)
      S_IDLE: if (pending || req_now) state_nxt = S_LOAD;
      S_LOAD: state_nxt = S_SEND;
      S_SEND: begin
        o_tx_valid = 1'b1;
        if (idx == IW'(0))      o_tx_data = HDR0;
        else if (idx == IW'(1)) o_tx_data = HDR1;
        else if (idx == IW'(2)) o_tx_data = len;
`ifdef FRAME_CHECKSUM_EN
        else if (idx == last_idx) o_tx_data = chk;
`endif
        else                    o_tx_data = pbyte;
        if (i_tx_ready && idx == last_idx) begin
          o_frame_done = 1'b1;
          state_nxt    = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_frame_sender.sv
// Self-checking bench for uart_frame_sender: expected bytes are queued when a
// frame is requested and compared as the DUT hands bytes to the UART.
module tb_uart_frame_sender;

  localparam int unsigned MAXP = 8;
`ifdef FRAME_CHECKSUM_EN
  localparam int CHK = 1;
`else
  localparam int CHK = 0;
`endif

  typedef struct {
    logic [7:0] data;
    logic       last;
  } exp_t;

  logic              clk_a = 1'b0;
  logic              rst_n = 1'b0;
  logic [8*MAXP-1:0] i_payload = '0;
  logic [7:0]        i_len = '0;
  logic              i_auto_en = 1'b0;
  logic              i_trigger = 1'b0;
  logic              i_tx_ready = 1'b1;
  logic [7:0]        o_tx_data;
  logic              o_tx_valid;
  logic              o_busy;
  logic              o_frame_done;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  uart_frame_sender #(
    .PERIOD_CYCLES(1000),
    .MAX_PAYLOAD  (MAXP),
    .HDR0         (8'h55),
    .HDR1         (8'h5A)
  ) dut (
    .clk_a       (clk_a),
    .rst_n       (rst_n),
    .i_payload   (i_payload),
    .i_len       (i_len),
    .i_auto_en   (i_auto_en),
    .i_trigger   (i_trigger),
    .o_tx_data   (o_tx_data),
    .o_tx_valid  (o_tx_valid),
    .i_tx_ready  (i_tx_ready),
    .o_busy      (o_busy),
    .o_frame_done(o_frame_done)
  );

  always #5 clk_a = ~clk_a;

  task automatic push_frame(input logic [7:0] len_req, input logic [8*MAXP-1:0] pl);
    int n;
    logic [7:0] s;
    logic [7:0] b;
    n = (len_req > 8'(MAXP)) ? MAXP : int'(len_req);
    s = 8'(n);
    sb.push_back('{8'h55, 1'b0});
    sb.push_back('{8'h5A, 1'b0});
    sb.push_back('{8'(n), (n == 0 && CHK == 0)});
    for (int k = 0; k < n; k++) begin
      b = pl[8*k +: 8];
      s = s + b;
      sb.push_back('{b, (k == n - 1 && CHK == 0)});
    end
    if (CHK != 0) sb.push_back('{s, 1'b1});
  endtask

  // Scoreboard consumer: a byte is taken when valid&ready at the next posedge.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk_a);
      if (rst_n && o_tx_valid && i_tx_ready) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_byte: got %02h, required none", o_tx_data);
        end else begin
          e = sb.pop_front();
          if (o_tx_data !== e.data) begin
            miscompares++;
            $display("FAIL tx_data: got %02h, required %02h", o_tx_data, e.data);
          end
          vectors++;
          if (o_frame_done !== e.last) begin
            miscompares++;
            $display("FAIL frame_done: got %b, required %b", o_frame_done, e.last);
          end
        end
      end else if (o_frame_done !== 1'b0) begin
        vectors++;
        miscompares++;
        $display("FAIL spurious_done: got %b, required 0", o_frame_done);
      end
    end
  endtask

  task automatic pulse_trigger();
    @(posedge clk_a); #1 i_trigger = 1'b1;
    @(posedge clk_a); #1 i_trigger = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk_a); #1;
      n++;
    end
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL %s_drain: got %0d bytes left, required 0", name, sb.size());
      sb.delete();
    end
    @(posedge clk_a); #1;
    vectors++;
    if (o_busy !== 1'b0 || o_tx_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_idle: got busy=%b valid=%b, required 0 0", name, o_busy, o_tx_valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk_a);
    #1;
    vectors++;
    if (o_tx_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid: got %b, required 0", o_tx_valid); end
    vectors++;
    if (o_busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b, required 0", o_busy); end
    vectors++;
    if (o_frame_done !== 1'b0) begin miscompares++; $display("FAIL rst_done: got %b, required 0", o_frame_done); end
    vectors++;
    if (o_tx_data !== 8'h00) begin miscompares++; $display("FAIL rst_data: got %02h, required 00", o_tx_data); end
    rst_n = 1'b1;
    repeat (3) @(posedge clk_a);
    #1;
    vectors++;
    if (o_busy !== 1'b0) begin miscompares++; $display("FAIL post_rst_busy: got %b, required 0", o_busy); end
  endtask

  task automatic test_basic();
    int n = 0;
    i_tx_ready = 1'b1;
    i_len = 8'd2;
    i_payload = 64'h84D3;
    push_frame(i_len, i_payload);
    pulse_trigger();
    vectors++;
    if (o_busy !== 1'b1 || o_tx_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL load_cycle: got busy=%b valid=%b, required 1 0", o_busy, o_tx_valid);
    end
    @(posedge clk_a); #1;
    vectors++;
    if (o_tx_valid !== 1'b1 || o_tx_data !== 8'h55) begin
      miscompares++;
      $display("FAIL latency: got valid=%b data=%02h, required 1 55", o_tx_valid, o_tx_data);
    end
    while (sb.size() != 0 && n < 50) begin
      @(negedge clk_a); #1;
      n++;
    end
    vectors++;
    if (n != 5 + CHK) begin
      miscompares++;
      $display("FAIL back_to_back: got %0d cycles, required %0d", n, 5 + CHK);
    end
    drain("basic");
  endtask

  task automatic test_stall();
    int n = 0;
    i_tx_ready = 1'b0;
    push_frame(i_len, i_payload);
    pulse_trigger();
    while (o_tx_valid !== 1'b1 && n < 10) begin
      @(posedge clk_a); #1;
      n++;
    end
    i_tx_ready = 1'b1;
    @(posedge clk_a); #1;
    i_tx_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk_a); #1;
      vectors++;
      if (o_tx_valid !== 1'b1 || o_tx_data !== 8'h5A) begin
        miscompares++;
        $display("FAIL stall_hold: got valid=%b data=%02h, required 1 5A", o_tx_valid, o_tx_data);
      end
    end
    i_tx_ready = 1'b1;
    drain("stall");
  endtask

  task automatic test_auto_period();
    int r[3];
    int nr = 0;
    int cyc = 0;
    logic prev = 1'b0;
    i_tx_ready = 1'b1;
    for (int f = 0; f < 3; f++) push_frame(i_len, i_payload);
    i_auto_en = 1'b1;
    while (nr < 3 && cyc < 2500) begin
      @(posedge clk_a); #1;
      cyc++;
      i_trigger = 1'b0;
      if (o_tx_valid && !prev) begin
        r[nr] = cyc;
        if (nr == 0) i_trigger = 1'b1;
        nr++;
      end
      prev = o_tx_valid;
    end
    i_auto_en = 1'b0;
    i_trigger = 1'b0;
    vectors++;
    if (nr != 3) begin
      miscompares++;
      $display("FAIL auto_frames: got %0d starts, required 3", nr);
    end else begin
      vectors++;
      if (r[1] - r[0] != 7 + CHK) begin
        miscompares++;
        $display("FAIL pending_gap: got %0d, required %0d", r[1] - r[0], 7 + CHK);
      end
      vectors++;
      if (r[2] - r[0] != 1000) begin
        miscompares++;
        $display("FAIL period: got %0d, required 1000", r[2] - r[0]);
      end
    end
    drain("auto");
  endtask

  task automatic test_len_edges();
    i_tx_ready = 1'b1;
    i_len = 8'd0;
    push_frame(i_len, i_payload);
    pulse_trigger();
    drain("len0");
    i_len = 8'd12;
    i_payload = {$urandom, $urandom};
    push_frame(i_len, i_payload);
    pulse_trigger();
    @(posedge clk_a); #1;
    i_payload = ~i_payload;
    i_len = 8'd3;
    drain("len12");
    i_len = 8'd2;
    i_payload = 64'h84D3;
  endtask

  task automatic test_reset_mid();
    int n = 0;
    logic stray = 1'b0;
    i_tx_ready = 1'b1;
    push_frame(i_len, i_payload);
    pulse_trigger();
    while (!(o_tx_valid === 1'b1 && o_tx_data === 8'h84) && n < 20) begin
      @(posedge clk_a); #1;
      n++;
    end
    #1 rst_n = 1'b0;
    #1;
    vectors++;
    if (o_tx_valid !== 1'b0 || o_busy !== 1'b0 || o_frame_done !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset: got valid=%b busy=%b done=%b, required 0 0 0",
               o_tx_valid, o_busy, o_frame_done);
    end
    sb.delete();
    repeat (2) @(posedge clk_a);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk_a); #1;
      if (o_tx_valid !== 1'b0 || o_busy !== 1'b0) stray = 1'b1;
    end
    vectors++;
    if (stray) begin
      miscompares++;
      $display("FAIL idle_after_reset: got activity, required none");
    end
    push_frame(i_len, i_payload);
    pulse_trigger();
    drain("after_reset");
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_basic();
    test_stall();
    test_auto_period();
    test_len_edges();
    test_reset_mid();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL leftover: got %0d, required 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
